// File: rtl/otter_pkg.sv
// Shared OTTER control definitions: control-unit states and RV32I base opcodes.
// Both the control FSM and the combinational decoder import these definitions.
package otter_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } cu_state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

endpackage

// File: rtl/otter_cu_fsm.sv
// OTTER multi-cycle control unit: sequences INIT/FETCH/EXEC/WB, drives write strobes, counts INSTRET.
// Define OTTER_INTR_EN to enable interrupt entry through ST_INTR on retire cycles.
module otter_cu_fsm
  import otter_pkg::*;
#(
  parameter int INIT_CYCLES = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct,
  input  logic             dmem_rdy,
  input  logic             intr,
  input  logic             mie,
  output logic             pc_write,
  output logic             reg_write,
  output logic             mem_rden1,
  output logic             mem_rden2,
  output logic             mem_we2,
  output logic             rf_rst,
  output logic             csr_we,
  output logic             mret_exec,
  output logic             illegal,
  output logic             int_taken,
  output logic [CNT_W-1:0] instret
);

  localparam int            IW        = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);

  cu_state_t     state_q, state_d, retire_next;
  logic [IW-1:0] init_cnt;
  logic          irq;

`ifdef OTTER_INTR_EN
  assign irq = intr & mie;
`else
  logic intr_unused;
  assign intr_unused = intr ^ mie;
  assign irq         = 1'b0;
`endif

  // Async reset lands in ST_INIT, so rf_rst is asserted straight from the state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      init_cnt <= '0;
      instret  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT && init_cnt != INIT_LAST)
        init_cnt <= init_cnt + IW'(1);
      if (pc_write && state_q != ST_INTR)
        instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    mem_rden1   = 1'b0;
    mem_rden2   = 1'b0;
    mem_we2     = 1'b0;
    rf_rst      = 1'b0;
    csr_we      = 1'b0;
    mret_exec   = 1'b0;
    illegal     = 1'b0;
    int_taken   = 1'b0;
    retire_next = irq ? ST_INTR : ST_FETCH;

    case (state_q)
      ST_INIT: begin
        rf_rst = 1'b1;
        if (init_cnt == INIT_LAST) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        mem_rden1 = 1'b1;
        state_d   = ST_EXEC;
      end

      ST_EXEC: begin
        pc_write = 1'b1;
        state_d  = retire_next;
        case (opcode)
          OP_RTYPE, OP_ITYPE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR:
            reg_write = 1'b1;
          OP_BRANCH: ;
          OP_STORE:
            mem_we2 = 1'b1;
          OP_LOAD: begin
            // Load retires in ST_WB once data is valid, not here.
            pc_write  = 1'b0;
            mem_rden2 = 1'b1;
            state_d   = ST_WB;
          end
          OP_SYS: begin
            if (funct != 3'b000) begin
              reg_write = 1'b1;
              csr_we    = 1'b1;
            end else begin
              mret_exec = 1'b1;
            end
          end
          default:
            illegal = 1'b1;
        endcase
      end

      ST_WB: begin
        mem_rden2 = 1'b1;
        if (dmem_rdy) begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          state_d   = retire_next;
        end
      end

      ST_INTR: begin
`ifdef OTTER_INTR_EN
        int_taken = 1'b1;
        pc_write  = 1'b1;
`endif
        state_d = ST_FETCH;
      end

      default: state_d = ST_INIT;
    endcase
  end

endmodule
